display_receiver: RTL and testbench
===================================

DISPLAY_RECEIVER -- requirements
Module: display_receiver

Interface
REQ-001 Parameter MATCH_FRAMES, default 2, sets how many consecutive identical complete frames are needed before time_valid asserts (legal range 1..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 pins  input  8  multiplexed 4x4 display bus; pins[7:4] = row strobes (active low, one-hot-zero), pins[3:0] = column data for the strobed row.
REQ-005 frame  output  16  last complete frame; bits [4r+3:4r] = columns of row r.
REQ-006 frame_valid  output  1  one-cycle pulse when frame updates.
REQ-007 changed  output  1  one-cycle pulse, coincident with frame_valid, when the new frame differs from the previous frame value.
REQ-008 hours  output  5  frame[10:6].
REQ-009 minutes  output  6  frame[5:0].
REQ-010 time_valid  output  1  level; decoded time is stable and in range.
REQ-011 err_row  output  1  one-cycle pulse on an illegal row pattern.
REQ-012 err_seq  output  1  one-cycle pulse on an out-of-order row.
REQ-013 err_range  output  1  one-cycle pulse, coincident with frame_valid, when the completed frame fails the range check.

Function
REQ-014 pins SHALL pass through one input register (sample stage) before decoding; all decode acts on the sampled value.
REQ-015 Row decode SHALL be: 1110 -> row 0; 1101 -> row 1; 1011 -> row 2; 0111 -> row 3; 0000 -> bus idle; any other value -> illegal.
REQ-016 States SHALL be HUNT and CAPTURE(k), where k in 0..3 is the next expected row.
REQ-017 HUNT: sampled row 0 -> store cols in slot 0, go to CAPTURE(1); rows 1..3 -> stay, no error; idle -> stay.
REQ-018 CAPTURE(k): row k -> store cols in slot k; if k<3, go to CAPTURE(k+1); if k=3, complete the frame and go to CAPTURE(0).
REQ-019 CAPTURE(k): row k-1 (mod 4) repeated -> overwrite that slot and stay; repeats are not errors.
REQ-020 CAPTURE(k), k!=0: sampled row 0 -> err_seq, store slot 0, go to CAPTURE(1); any other out-of-order row -> err_seq, discard partial, go to HUNT.
REQ-021 In CAPTURE(0), row 0 is the expected row and is handled by REQ-018; rows 1..2 -> err_seq, go to HUNT.
REQ-022 Idle SHALL discard any partial frame and go to HUNT with no error pulse; an illegal pattern SHALL pulse err_row, discard, and go to HUNT.
REQ-023 Frame completion SHALL load frame with {slot3,slot2,slot1,slot0} and pulse frame_valid in the cycle 2 clocks after the row-3 pattern is on pins (sample stage + decode/store stage).
REQ-024 changed SHALL pulse iff the new frame != the frame value held immediately before the update.
REQ-025 The range check SHALL pass iff frame[15:11]==0, hours<24 and minutes<60; on failure, err_range pulses.
REQ-026 The match counter is 4-bit and saturates at MATCH_FRAMES; it SHALL increment on a completed frame equal to the previous frame and otherwise load 1.
REQ-027 time_valid SHALL be registered high iff match count >= MATCH_FRAMES and the latest frame passes the range check; it updates only on frame completion or reset.
REQ-028 Idle or error events SHALL NOT change frame, hours, minutes or time_valid.

Reset
REQ-029 While rst is high at a clock edge, all registers clear: sample register=8'h00 (idle), state=HUNT, slots=0, frame=0, match count=0, and all pulse outputs and time_valid=0.
REQ-030 Reset mid-capture SHALL discard the partial frame; the first frame after reset compares against frame=0 for changed.

Verification
REQ-031 Reset, then rows 0..3 cycle with frame 16'h0285 (10:05) for 3 frames -> frame_valid every 4 cycles; changed on frame 1 only; time_valid high from frame 2; hours=10, minutes=5.
REQ-032 Stream 0x0285 then switch to 0x02C5 -> changed pulse, time_valid drops at that frame and returns on the next identical frame.
REQ-033 Frame 16'h0640 (hours=25) repeated -> err_range on each completion; time_valid stays 0.
REQ-034 Rows 0,1,3 sequence -> err_seq at row 3 with state HUNT; next clean rows 0..3 -> frame_valid with no further error.
REQ-035 Row pattern 1100 mid-frame -> err_row, no frame_valid for that frame; pins=0000 mid-frame -> no error, partial frame discarded.
REQ-036 Each row held 3 cycles (repeats) -> one frame_valid per 12 cycles, no errors; rst asserted during row 2 -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/display_receiver.sv
// Decodes a multiplexed 4x4 row/column display bus into 16-bit frames and a validated HH:MM time.
// Latency: a frame is published two clocks after its row-3 pattern is on pins; the bus has no backpressure.
module display_receiver #(
    parameter int unsigned MATCH_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pins,
    output logic [15:0] frame,
    output logic        frame_valid,
    output logic        changed,
    output logic [4:0]  hours,
    output logic [5:0]  minutes,
    output logic        time_valid,
    output logic        err_row,
    output logic        err_seq,
    output logic        err_range
);

    localparam logic [3:0] MATCH_LIM = 4'(MATCH_FRAMES);

    typedef enum logic [2:0] {
        S_HUNT,
        S_CAP0,
        S_CAP1,
        S_CAP2,
        S_CAP3
    } state_t;

    typedef enum logic [1:0] {
        ROW_IDLE,
        ROW_HIT,
        ROW_BAD
    } row_kind_t;

    logic [7:0]      pins_q, pins_d;
    state_t          state_q, state_d;
    logic [3:0][3:0] slot_q, slot_d;
    logic [15:0]     frame_q, frame_d;
    logic [3:0]      match_q, match_d;
    logic            frame_valid_q, frame_valid_d;
    logic            changed_q, changed_d;
    logic            time_valid_q, time_valid_d;
    logic            err_row_q, err_row_d;
    logic            err_seq_q, err_seq_d;
    logic            err_range_q, err_range_d;

    row_kind_t       row_kind;
    logic [1:0]      row_idx;
    logic [3:0]      cols;
    logic [1:0]      exp_idx;
    logic [1:0]      prev_idx;
    logic            complete;
    logic [15:0]     new_frame;
    logic            range_ok;

    function automatic logic [1:0] exp_of(input state_t s);
        logic [1:0] k;
        case (s)
            S_CAP1:  k = 2'd1;
            S_CAP2:  k = 2'd2;
            S_CAP3:  k = 2'd3;
            default: k = 2'd0;
        endcase
        return k;
    endfunction

    function automatic state_t cap_of(input logic [1:0] k);
        state_t s;
        case (k)
            2'd1:    s = S_CAP1;
            2'd2:    s = S_CAP2;
            2'd3:    s = S_CAP3;
            default: s = S_CAP0;
        endcase
        return s;
    endfunction

    assign pins_d = pins;
    assign cols   = pins_q[3:0];

    // Row strobes are active low; exactly one low strobe selects a row.
    always_comb begin
        row_kind = ROW_BAD;
        row_idx  = 2'd0;
        case (pins_q[7:4])
            4'b1110: begin row_kind = ROW_HIT; row_idx = 2'd0; end
            4'b1101: begin row_kind = ROW_HIT; row_idx = 2'd1; end
            4'b1011: begin row_kind = ROW_HIT; row_idx = 2'd2; end
            4'b0111: begin row_kind = ROW_HIT; row_idx = 2'd3; end
            4'b0000: row_kind = ROW_IDLE;
            default: row_kind = ROW_BAD;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        err_row_d = 1'b0;
        err_seq_d = 1'b0;
        complete  = 1'b0;
        exp_idx   = exp_of(state_q);
        prev_idx  = exp_idx - 2'd1;
        case (row_kind)
            ROW_IDLE: state_d = S_HUNT;
            ROW_BAD: begin
                err_row_d = 1'b1;
                state_d   = S_HUNT;
            end
            default: begin
                if (state_q == S_HUNT) begin
                    if (row_idx == 2'd0) begin
                        slot_d[0] = cols;
                        state_d   = S_CAP1;
                    end
                end else if (row_idx == exp_idx) begin
                    slot_d[row_idx] = cols;
                    state_d         = cap_of(exp_idx + 2'd1);
                    complete        = (exp_idx == 2'd3);
                end else if (row_idx == prev_idx) begin
                    // A row held across several scans just refreshes its slot.
                    slot_d[row_idx] = cols;
                end else begin
                    err_seq_d = 1'b1;
                    if (row_idx == 2'd0) begin
                        slot_d[0] = cols;
                        state_d   = S_CAP1;
                    end else begin
                        state_d = S_HUNT;
                    end
                end
            end
        endcase
    end

    assign new_frame = slot_d;
    assign range_ok  = (new_frame[15:11] == 5'd0) && (new_frame[10:6] < 5'd24)
                       && (new_frame[5:0] < 6'd60);

    always_comb begin
        frame_d       = frame_q;
        match_d       = match_q;
        time_valid_d  = time_valid_q;
        frame_valid_d = 1'b0;
        changed_d     = 1'b0;
        err_range_d   = 1'b0;
        if (complete) begin
            frame_d       = new_frame;
            frame_valid_d = 1'b1;
            changed_d     = (new_frame != frame_q);
            if (new_frame == frame_q) begin
                match_d = (match_q >= MATCH_LIM) ? MATCH_LIM : match_q + 4'd1;
            end else begin
                match_d = 4'd1;
            end
            err_range_d  = !range_ok;
            time_valid_d = (match_d >= MATCH_LIM) && range_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pins_q        <= 8'h00;
            state_q       <= S_HUNT;
            slot_q        <= '0;
            frame_q       <= 16'h0000;
            match_q       <= 4'd0;
            frame_valid_q <= 1'b0;
            changed_q     <= 1'b0;
            time_valid_q  <= 1'b0;
            err_row_q     <= 1'b0;
            err_seq_q     <= 1'b0;
            err_range_q   <= 1'b0;
        end else begin
            pins_q        <= pins_d;
            state_q       <= state_d;
            slot_q        <= slot_d;
            frame_q       <= frame_d;
            match_q       <= match_d;
            frame_valid_q <= frame_valid_d;
            changed_q     <= changed_d;
            time_valid_q  <= time_valid_d;
            err_row_q     <= err_row_d;
            err_seq_q     <= err_seq_d;
            err_range_q   <= err_range_d;
        end
    end

    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
    assign changed     = changed_q;
    assign hours       = frame_q[10:6];
    assign minutes     = frame_q[5:0];
    assign time_valid  = time_valid_q;
    assign err_row     = err_row_q;
    assign err_seq     = err_seq_q;
    assign err_range   = err_range_q;

endmodule

// File: tb/tb_display_receiver.sv
// Directed bench for display_receiver: a behavioural frame/time model is compared every cycle,
// and literal expectations pin the model at the end of each scenario.
module tb_display_receiver;

    localparam int MF = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pins;
    logic [15:0] frame;
    logic        frame_valid, changed, time_valid, err_row, err_seq, err_range;
    logic [4:0]  hours;
    logic [5:0]  minutes;

    always #5 clk = ~clk;

    display_receiver #(.MATCH_FRAMES(MF)) dut (
        .clk         (clk),
        .rst         (rst),
        .pins        (pins),
        .frame       (frame),
        .frame_valid (frame_valid),
        .changed     (changed),
        .hours       (hours),
        .minutes     (minutes),
        .time_valid  (time_valid),
        .err_row     (err_row),
        .err_seq     (err_seq),
        .err_range   (err_range)
    );

    int errors = 0;
    int checks = 0;
    int fv_cnt = 0, chg_cnt = 0, erow_cnt = 0, eseq_cnt = 0, erng_cnt = 0;

    // Model state: expected next row (-1 while hunting), partial row columns, published frame.
    logic [7:0]  m_sample;
    int          m_exp;
    logic [3:0]  m_part [4];
    logic [15:0] m_frame;
    int          m_match;
    logic        m_fv, m_chg, m_tv, m_erow, m_eseq, m_erng;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_complete();
        logic [15:0] f;
        logic        ok;
        f      = {m_part[3], m_part[2], m_part[1], m_part[0]};
        ok     = (f[15:11] == 5'd0) && (int'(f[10:6]) < 24) && (int'(f[5:0]) < 60);
        m_chg  = (f != m_frame);
        if (f == m_frame) m_match = (m_match + 1 > MF) ? MF : m_match + 1;
        else              m_match = 1;
        m_frame = f;
        m_fv    = 1'b1;
        m_erng  = !ok;
        m_tv    = (m_match >= MF) && ok;
    endtask

    task automatic model_step(input logic r, input logic [7:0] p);
        int         row;
        logic [3:0] c;
        m_fv = 1'b0; m_chg = 1'b0; m_erow = 1'b0; m_eseq = 1'b0; m_erng = 1'b0;
        if (r) begin
            m_sample = 8'h00;
            m_exp    = -1;
            for (int i = 0; i < 4; i++) m_part[i] = 4'h0;
            m_frame  = 16'h0000;
            m_match  = 0;
            m_tv     = 1'b0;
        end else begin
            c = m_sample[3:0];
            case (m_sample[7:4])
                4'b1110: row = 0;
                4'b1101: row = 1;
                4'b1011: row = 2;
                4'b0111: row = 3;
                4'b0000: row = -1;
                default: row = -2;
            endcase
            if (row == -1) begin
                m_exp = -1;
            end else if (row == -2) begin
                m_erow = 1'b1;
                m_exp  = -1;
            end else if (m_exp == -1) begin
                if (row == 0) begin m_part[0] = c; m_exp = 1; end
            end else if (row == m_exp) begin
                m_part[row] = c;
                if (row == 3) model_complete();
                m_exp = (m_exp + 1) % 4;
            end else if (row == (m_exp + 3) % 4) begin
                m_part[row] = c;
            end else begin
                m_eseq = 1'b1;
                if (row == 0) begin m_part[0] = c; m_exp = 1; end
                else m_exp = -1;
            end
            m_sample = p;
        end
    endtask

    task automatic step(input logic [7:0] p);
        pins = p;
        @(posedge clk);
        model_step(rst, pins);
        #1;
        chk("frame", frame, m_frame);
        chk("frame_valid", 16'(frame_valid), 16'(m_fv));
        chk("changed", 16'(changed), 16'(m_chg));
        chk("hours", 16'(hours), 16'(m_frame[10:6]));
        chk("minutes", 16'(minutes), 16'(m_frame[5:0]));
        chk("time_valid", 16'(time_valid), 16'(m_tv));
        chk("err_row", 16'(err_row), 16'(m_erow));
        chk("err_seq", 16'(err_seq), 16'(m_eseq));
        chk("err_range", 16'(err_range), 16'(m_erng));
        fv_cnt   += int'(frame_valid);
        chg_cnt  += int'(changed);
        erow_cnt += int'(err_row);
        eseq_cnt += int'(err_seq);
        erng_cnt += int'(err_range);
    endtask

    function automatic logic [7:0] row_pins(input int r, input logic [3:0] c);
        logic [3:0] s;
        s = ~(4'b0001 << r);
        return {s, c};
    endfunction

    task automatic send_frame(input logic [15:0] f, input int hold);
        for (int r = 0; r < 4; r++)
            for (int h = 0; h < hold; h++)
                step(row_pins(r, f[4*r +: 4]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'h00);
    endtask

    int b_fv, b_chg, b_erow, b_eseq, b_erng;

    task automatic snap();
        b_fv = fv_cnt; b_chg = chg_cnt; b_erow = erow_cnt; b_eseq = eseq_cnt; b_erng = erng_cnt;
    endtask

    logic [15:0] bnd_frame [3];
    logic        bnd_tv    [3];
    int          bnd_rng   [3];

    initial begin
        bnd_frame[0] = 16'h05FB; bnd_tv[0] = 1'b1; bnd_rng[0] = 0;
        bnd_frame[1] = 16'h003C; bnd_tv[1] = 1'b0; bnd_rng[1] = 2;
        bnd_frame[2] = 16'h0800; bnd_tv[2] = 1'b0; bnd_rng[2] = 2;

        rst  = 1'b1;
        pins = 8'h00;
        repeat (3) step(8'h00);
        chk("reset_frame", frame, 16'h0000);
        chk("reset_time_valid", 16'(time_valid), 16'h0);
        rst = 1'b0;

        // 10:05 streamed back to back three times
        snap();
        repeat (3) send_frame(16'h0285, 1);
        idle(2);
        chk("s1_fv_count", 16'(fv_cnt - b_fv), 16'd3);
        chk("s1_changed_count", 16'(chg_cnt - b_chg), 16'd1);
        chk("s1_time_valid", 16'(time_valid), 16'd1);
        chk("s1_hours", 16'(hours), 16'd10);
        chk("s1_minutes", 16'(minutes), 16'd5);

        // switch to 11:05: drops validity, then regains it
        snap();
        send_frame(16'h0285, 1);
        send_frame(16'h02C5, 1);
        idle(2);
        chk("s2_tv_after_change", 16'(time_valid), 16'd0);
        chk("s2_changed_count", 16'(chg_cnt - b_chg), 16'd1);
        send_frame(16'h02C5, 1);
        idle(2);
        chk("s2_tv_regained", 16'(time_valid), 16'd1);
        chk("s2_hours", 16'(hours), 16'd11);

        // hours=25 never becomes valid
        snap();
        repeat (3) begin send_frame(16'h0640, 1); idle(2); end
        chk("s3_err_range_count", 16'(erng_cnt - b_erng), 16'd3);
        chk("s3_time_valid", 16'(time_valid), 16'd0);
        chk("s3_hours", 16'(hours), 16'd25);

        // rows 0,1,3 then a clean frame
        snap();
        step(row_pins(0, 4'h5));
        step(row_pins(1, 4'h8));
        step(row_pins(3, 4'h0));
        send_frame(16'h0285, 1);
        idle(2);
        chk("s4_err_seq_count", 16'(eseq_cnt - b_eseq), 16'd1);
        chk("s4_fv_count", 16'(fv_cnt - b_fv), 16'd1);
        chk("s4_frame", frame, 16'h0285);

        // illegal strobe mid-frame, then idle mid-frame
        snap();
        step(row_pins(0, 4'h1));
        step(row_pins(1, 4'h2));
        step(8'hC3);
        step(row_pins(2, 4'h3));
        step(row_pins(3, 4'h4));
        idle(2);
        step(row_pins(0, 4'h1));
        step(row_pins(1, 4'h2));
        step(8'h00);
        step(row_pins(2, 4'h3));
        step(row_pins(3, 4'h4));
        idle(2);
        chk("s5_err_row_count", 16'(erow_cnt - b_erow), 16'd1);
        chk("s5_err_seq_count", 16'(eseq_cnt - b_eseq), 16'd0);
        chk("s5_fv_count", 16'(fv_cnt - b_fv), 16'd0);
        chk("s5_frame_kept", frame, 16'h0285);

        // each row held for three scans
        snap();
        send_frame(16'h02C5, 3);
        send_frame(16'h02C5, 3);
        idle(2);
        chk("s6_fv_count", 16'(fv_cnt - b_fv), 16'd2);
        chk("s6_err_count", 16'((eseq_cnt - b_eseq) + (erow_cnt - b_erow)), 16'd0);
        chk("s6_time_valid", 16'(time_valid), 16'd1);

        // reset during row 2, then a zero frame compares against the cleared frame
        step(row_pins(0, 4'h5)); step(row_pins(0, 4'h5)); step(row_pins(0, 4'h5));
        step(row_pins(1, 4'h8)); step(row_pins(1, 4'h8)); step(row_pins(1, 4'h8));
        rst = 1'b1;
        step(row_pins(2, 4'h2));
        chk("s7_rst_frame", frame, 16'h0000);
        chk("s7_rst_tv", 16'(time_valid), 16'd0);
        chk("s7_rst_fv", 16'(frame_valid), 16'd0);
        rst = 1'b0;
        snap();
        send_frame(16'h0000, 1);
        idle(2);
        chk("s7_fv_count", 16'(fv_cnt - b_fv), 16'd1);
        chk("s7_changed_count", 16'(chg_cnt - b_chg), 16'd0);
        chk("s7_tv_first", 16'(time_valid), 16'd0);
        send_frame(16'h0000, 1);
        idle(2);
        chk("s7_tv_second", 16'(time_valid), 16'd1);

        // range boundaries: 23:59 passes, minute 60 and high bits fail
        for (int i = 0; i < 3; i++) begin
            snap();
            repeat (2) begin send_frame(bnd_frame[i], 1); idle(2); end
            chk("bnd_time_valid", 16'(time_valid), 16'(bnd_tv[i]));
            chk("bnd_err_range_count", 16'(erng_cnt - b_erng), 16'(bnd_rng[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
